// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: MDOp encodings used by the
// E-stage decoder and hazard unit, FSM state encodings, and small decode
// helpers.
package md_unit_pkg;

  // Operation codes carried on MDOp.
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // FSM state encodings.
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Bundle of the E-stage <-> multiply/divide unit signals.
//   Start  : 1-cycle pulse starting a mult/multu/div/divu
//   MDOp   : operation code (md_unit_pkg::MD_*)
//   A, B   : rs / rt operands (already forwarded)
//   Busy   : multi-cycle operation in progress
//   HI_out : current HI register
//   LO_out : current LO register
//   MD_out : mfhi/mflo read data, 0 for any other MDOp
// master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MD_out;

  modport master (output Start, MDOp, A, B, input Busy, HI_out, LO_out, MD_out);
  modport slave  (input Start, MDOp, A, B, output Busy, HI_out, LO_out, MD_out);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Owns HI/LO.
// The result of mult/multu/div/divu is computed at the Start edge, parked in
// tmp_hi/tmp_lo, and committed to HI/LO at the edge where Busy falls, so the
// pipeline sees the timing of a multi-cycle unit.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-low; clears HI/LO and aborts any operation
//   md    : md_unit_if.slave (Start, MDOp, A, B, Busy, HI_out, LO_out, MD_out)
import md_unit_pkg::*;

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      tmp_hi, tmp_lo;
  logic             div0;

  logic [31:0]        div_b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        res_hi, res_lo;

  // Results for every op are formed combinationally from the operands; only
  // the one selected by MDOp is latched at the Start edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    res_hi = '0;
    res_lo = '0;
    // A zero divisor is replaced by 1 so the dividers never produce X; the
    // result is discarded at commit anyway.
    div_b  = (md.B == 32'd0) ? 32'd1 : md.B;
    prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u = {32'd0, md.A} * {32'd0, md.B};
    quot_s = $signed(md.A) / $signed(div_b);
    rem_s  = $signed(md.A) % $signed(div_b);
    case (md.MDOp)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_hi = rem_s;
        res_lo = quot_s;
      end
      MD_DIVU: begin
        res_hi = md.A % div_b;
        res_lo = md.A / div_b;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      div0   <= 1'b0;
    end else if (state == MD_IDLE) begin
      if (md.Start && is_arith(md.MDOp)) begin
        state  <= MD_RUN;
        cnt    <= is_div(md.MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        tmp_hi <= res_hi;
        tmp_lo <= res_lo;
        div0   <= is_div(md.MDOp) && (md.B == 32'd0);
      end else if (md.MDOp == MD_MTHI) begin
        hi <= md.A;
      end else if (md.MDOp == MD_MTLO) begin
        lo <= md.A;
      end
    end else begin
      // RUN: Start/mthi/mtlo are ignored until the count expires.
      if (cnt == CNT_W'(1)) begin
        state <= MD_IDLE;
        cnt   <= '0;
        if (!div0) begin
          hi <= tmp_hi;
          lo <= tmp_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign md.Busy   = (state == MD_RUN);
  assign md.HI_out = hi;
  assign md.LO_out = lo;
  assign md.MD_out = (md.MDOp == MD_MFHI) ? hi :
                     (md.MDOp == MD_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized
// mult/multu/div/divu traffic checked against a plain-arithmetic HI/LO model.
import md_unit_pkg::*;

module tb_md_unit;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic clk;
  logic reset;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference HI/LO as the architecture defines them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    int unsigned     ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    case (op)
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb);
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      MD_MULTU: begin
        up = longint'(ua) * longint'(ub);
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MD_DIV:  if (b != 0) begin m_lo = sa / sb; m_hi = sa % sb; end
      MD_DIVU: if (b != 0) begin m_lo = ua / ub; m_hi = ua % ub; end
      default: ;
    endcase
  endfunction

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    bus.MDOp = op;
    bus.A    = a;
    tick();
    bus.MDOp = MD_NONE;
    if (op == MD_MTHI) m_hi = a;
    if (op == MD_MTLO) m_lo = a;
  endtask

  // Issue one multi-cycle op, optionally presenting a second MDOp/Start
  // during sample number inj_at of the busy window, then measure how long
  // Busy stays high and compare the committed HI/LO with the model.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input int inj_at,
                        input logic inj_start, input logic [3:0] inj_op,
                        input logic [31:0] inj_a, input logic [31:0] inj_b);
    int          cycles;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
    tick();
    bus.Start = 1'b0; bus.MDOp = MD_NONE;
    model(op, a, b);
    cycles = 0;
    while (bus.Busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (cycles == 1) begin
        check({tag, "_hold_hi"}, bus.HI_out, old_hi);
        check({tag, "_hold_lo"}, bus.LO_out, old_lo);
      end
      if (cycles == inj_at) begin
        bus.Start = inj_start; bus.MDOp = inj_op; bus.A = inj_a; bus.B = inj_b;
        tick();
        bus.Start = 1'b0; bus.MDOp = MD_NONE;
        check({tag, "_inj_hi"}, bus.HI_out, old_hi);
      end else begin
        tick();
      end
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
    check({tag, "_hi"}, bus.HI_out, m_hi);
    check({tag, "_lo"}, bus.LO_out, m_lo);
  endtask

  initial begin
    logic [3:0]  ops [4] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    logic [3:0]  op;
    logic [31:0] ra, rb;

    reset = 1'b0;
    bus.Start = 1'b0; bus.MDOp = MD_NONE; bus.A = '0; bus.B = '0;

    // Reset state.
    #3;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_hi", bus.HI_out, 32'd0);
    check("rst_lo", bus.LO_out, 32'd0);
    check("rst_md_out", bus.MD_out, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // mult -2 * 3.
    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, N_MULT, 0, 1'b0, MD_NONE, '0, '0);
    check("mult_neg_hi_const", bus.HI_out, 32'hFFFF_FFFF);
    check("mult_neg_lo_const", bus.LO_out, 32'hFFFF_FFFA);

    // divu 7/2 then div -7/2.
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, N_DIV, 0, 1'b0, MD_NONE, '0, '0);
    check("divu_lo_const", bus.LO_out, 32'd3);
    check("divu_hi_const", bus.HI_out, 32'd1);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, N_DIV, 0, 1'b0, MD_NONE, '0, '0);
    check("div_lo_const", bus.LO_out, 32'hFFFF_FFFD);
    check("div_hi_const", bus.HI_out, 32'hFFFF_FFFF);

    // mthi, then reads through MD_out.
    mt(MD_MTHI, 32'h1234);
    bus.MDOp = MD_MFLO; #1;
    check("mflo_after_mthi", bus.MD_out, m_lo);
    bus.MDOp = MD_MFHI; #1;
    check("mfhi_after_mthi", bus.MD_out, 32'h1234);
    bus.MDOp = MD_NONE;
    // mthi presented during RUN must not touch HI.
    run_op("mthi_in_run", MD_MULT, 32'd6, 32'd7, N_MULT, 2, 1'b0, MD_MTHI, 32'hDEAD_BEEF, '0);

    // Divide by zero leaves HI/LO unchanged.
    mt(MD_MTHI, 32'd5);
    mt(MD_MTLO, 32'd9);
    run_op("div_by_zero", MD_DIV, 32'd100, 32'd0, N_DIV, 0, 1'b0, MD_NONE, '0, '0);
    check("div0_hi_const", bus.HI_out, 32'd5);
    check("div0_lo_const", bus.LO_out, 32'd9);

    // Second Start during RUN (cnt=2) is ignored.
    run_op("start_in_run", MD_MULT, 32'd100, 32'd7, N_MULT, N_MULT - 1, 1'b1, MD_MULT, 32'd3, 32'd3);
    check("start_in_run_lo_const", bus.LO_out, 32'd700);

    // Unknown MDOp: no state change, MD_out = 0.
    bus.Start = 1'b1; bus.MDOp = 4'hF; bus.A = 32'hAAAA_5555; bus.B = 32'd1;
    tick();
    check("unk_busy", {31'd0, bus.Busy}, 32'd0);
    check("unk_md_out", bus.MD_out, 32'd0);
    check("unk_hi", bus.HI_out, m_hi);
    check("unk_lo", bus.LO_out, m_lo);
    bus.Start = 1'b0; bus.MDOp = MD_NONE;

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : 32'($urandom);
      if (i % 6 == 5) begin
        op = (i % 12 == 5) ? MD_DIV : MD_DIVU;
        rb = 32'd0;
      end
      if (op == MD_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      run_op($sformatf("rand%0d", i), op, ra, rb, is_div(op) ? N_DIV : N_MULT,
             0, 1'b0, MD_NONE, '0, '0);
      bus.MDOp = MD_MFHI; #1;
      check($sformatf("rand%0d_mfhi", i), bus.MD_out, m_hi);
      bus.MDOp = MD_MFLO; #1;
      check($sformatf("rand%0d_mflo", i), bus.MD_out, m_lo);
      bus.MDOp = MD_NONE;
      if (i % 4 == 1) mt(MD_MTLO, $urandom);
    end

    // Asynchronous reset mid-RUN (cnt=3), with non-zero HI/LO beforehand.
    mt(MD_MTHI, 32'hCAFE_0001);
    mt(MD_MTLO, 32'hCAFE_0002);
    bus.Start = 1'b1; bus.MDOp = MD_DIV; bus.A = 32'd50; bus.B = 32'd5;
    tick();
    bus.Start = 1'b0; bus.MDOp = MD_NONE;
    repeat (N_DIV - 3) tick();
    check("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("async_rst_hi", bus.HI_out, 32'd0);
    check("async_rst_lo", bus.LO_out, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) reset = 1'b1;
    repeat (N_DIV + 2) tick();
    check("post_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("post_rst_hi", bus.HI_out, 32'd0);
    check("post_rst_lo", bus.LO_out, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
